// File: rtl/mario_dl_pkg.sv
// -----------------------------------------------------------------------------
// mario_dl_pkg
// Shared definitions for the ROM/PROM download writer.
//   DL_ADDR_W  : width of the download byte address bus (DLADDR)
//   DL_DATA_W  : width of the download data bus (DLDATA)
//   dl_state_t : writer FSM states, also exported on the debug state port
// -----------------------------------------------------------------------------
package mario_dl_pkg;

    localparam int DL_ADDR_W = 17;
    localparam int DL_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_WORD = 3'd1,
        ST_WRITE     = 3'd2,
        ST_GAP       = 3'd3,
        ST_DONE      = 3'd4
    } dl_state_t;

endpackage

// File: rtl/mario_dl_csum.sv
// -----------------------------------------------------------------------------
// mario_dl_csum
// 8-bit modular byte accumulator used for the optional download checksum.
// Ports:
//   I_CLK_48M  in   system clock
//   I_RSTn     in   asynchronous active-low reset
//   clr        in   synchronous clear (wins over en)
//   en         in   add add_byte into the running sum this cycle
//   add_byte   in   byte to accumulate
//   sum        out  registered running sum, mod 256
// -----------------------------------------------------------------------------
module mario_dl_csum
    import mario_dl_pkg::*;
(
    input  logic                 I_CLK_48M,
    input  logic                 I_RSTn,
    input  logic                 clr,
    input  logic                 en,
    input  logic [DL_DATA_W-1:0] add_byte,
    output logic [DL_DATA_W-1:0] sum
);

    always_ff @(posedge I_CLK_48M or negedge I_RSTn) begin
        if (!I_RSTn) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum + add_byte;
        end
    end

endmodule

// File: rtl/mario_dl_writer.sv
// -----------------------------------------------------------------------------
// mario_dl_writer
// Takes 32-bit words from the host bridge FIFO and replays them as byte writes
// on the ROM/PROM download bus (DLADDR/DLDATA/DLWR), big-endian byte order,
// with sequential addresses starting at 0 after each I_START.
//
// Parameters:
//   TOTAL_BYTES : bytes in a complete download
//   WR_HOLD     : cycles O_DLWR stays high per byte (1..7)
//   GAP         : idle cycles after each strobe (0..7)
//
// Build option:
//   MARIO_DL_CHECKSUM_EN : when defined, O_CSUM accumulates written bytes and a
//                          mismatch against I_CSUM_EXP at completion sets O_ERR.
//                          When undefined, O_CSUM is 0 and I_CSUM_EXP is unused.
//
// Ports:
//   I_CLK_48M     in   system clock (rising edge)
//   I_RSTn        in   asynchronous active-low reset
//   I_START       in   one-cycle pulse: start/restart a load at address 0
//   I_WORD        in   host word, bits [31:24] written first
//   I_WORD_VALID  in   I_WORD is valid
//   O_WORD_READY  out  block accepts a word this cycle
//   I_CSUM_EXP    in   expected 8-bit byte sum
//   O_DLADDR      out  download byte address
//   O_DLDATA      out  download byte
//   O_DLWR        out  write strobe, active high
//   O_BUSY        out  load in progress
//   O_DONE        out  load complete (held until I_START / reset)
//   O_ERR         out  overflow or checksum mismatch (sticky)
//   O_CSUM        out  running byte sum
//   O_DBG_STATE   out  current FSM state (dl_state_t encoding)
//
// Handshake: a word transfers on a rising clock edge where both I_WORD_VALID
// and O_WORD_READY are high. The host must hold I_WORD stable while
// I_WORD_VALID is high and not yet accepted; O_WORD_READY does not depend on
// I_WORD_VALID. I_START on the same edge wins and the word is not consumed.
// -----------------------------------------------------------------------------
module mario_dl_writer
    import mario_dl_pkg::*;
#(
    parameter logic [DL_ADDR_W-1:0] TOTAL_BYTES = 17'd81920,
    parameter int                   WR_HOLD     = 2,
    parameter int                   GAP         = 1
) (
    input  logic                 I_CLK_48M,
    input  logic                 I_RSTn,
    input  logic                 I_START,
    input  logic [31:0]          I_WORD,
    input  logic                 I_WORD_VALID,
    output logic                 O_WORD_READY,
    input  logic [DL_DATA_W-1:0] I_CSUM_EXP,
    output logic [DL_ADDR_W-1:0] O_DLADDR,
    output logic [DL_DATA_W-1:0] O_DLDATA,
    output logic                 O_DLWR,
    output logic                 O_BUSY,
    output logic                 O_DONE,
    output logic                 O_ERR,
    output logic [DL_DATA_W-1:0] O_CSUM,
    output logic [2:0]           O_DBG_STATE
);

    // Terminal values of the shared phase counter. GAP_LAST is meaningless
    // when GAP is 0 because ST_GAP is never entered then.
    localparam logic [2:0] HOLD_LAST = 3'(WR_HOLD - 1);
    localparam logic [2:0] GAP_LAST  = 3'(GAP - 1);

    dl_state_t            state_q, state_d;
    logic [2:0]           phase_q, phase_d;
    logic [1:0]           byte_idx_q;
    logic [31:0]          word_q;        // unsent bytes, next one in [31:24]
    logic [DL_ADDR_W-1:0] byte_cnt_q;
    logic [DL_ADDR_W-1:0] byte_cnt_inc;
    logic                 last_byte;
    logic                 clear_all;
    logic                 accept;        // word handshake this cycle
    logic                 byte_done;     // current byte's strobe+gap finished
    logic                 next_byte;     // move on to next byte of same word
    logic                 overflow;      // surplus word drained in DONE
    logic                 csum_err;

    assign byte_cnt_inc = byte_cnt_q + 17'd1;
    // Counter is compared before it is stored, so it never passes TOTAL_BYTES.
    assign last_byte    = (byte_cnt_inc == TOTAL_BYTES);
    assign clear_all    = I_START | (state_q == ST_IDLE);
    assign next_byte    = byte_done & (state_d == ST_WRITE);
    assign O_DBG_STATE  = state_q;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge I_CLK_48M or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        accept    = 1'b0;
        byte_done = 1'b0;
        overflow  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_WAIT_WORD: begin
                if (I_WORD_VALID && O_WORD_READY) begin
                    accept  = 1'b1;
                    state_d = ST_WRITE;
                    phase_d = '0;
                end
            end
            ST_WRITE: begin
                if (phase_q == HOLD_LAST) begin
                    phase_d = '0;
                    if (GAP == 0) begin
                        byte_done = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            ST_GAP: begin
                if (phase_q == GAP_LAST) begin
                    phase_d   = '0;
                    byte_done = 1'b1;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            ST_DONE: begin
                if (I_WORD_VALID && O_WORD_READY) begin
                    overflow = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Post-byte decision, shared by the GAP exit and the GAP=0 path.
        // Hitting the total mid-word silently drops the word's remaining bytes.
        if (byte_done) begin
            if (last_byte) begin
                state_d = ST_DONE;
            end else if (byte_idx_q == 2'd3) begin
                state_d = ST_WAIT_WORD;
            end else begin
                state_d = ST_WRITE;
            end
        end

        // Restart overrides everything, including a coincident handshake.
        if (I_START) begin
            state_d   = ST_WAIT_WORD;
            phase_d   = '0;
            accept    = 1'b0;
            byte_done = 1'b0;
            overflow  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registered status outputs, decoded from the next state so they line
    // up with the state they describe.
    // ------------------------------------------------------------------
    always_ff @(posedge I_CLK_48M or negedge I_RSTn) begin
        if (!I_RSTn) begin
            O_WORD_READY <= 1'b0;
            O_BUSY       <= 1'b0;
            O_DONE       <= 1'b0;
            O_DLWR       <= 1'b0;
        end else begin
            O_WORD_READY <= (state_d == ST_WAIT_WORD) || (state_d == ST_DONE);
            O_BUSY       <= (state_d == ST_WAIT_WORD) || (state_d == ST_WRITE) ||
                            (state_d == ST_GAP);
            O_DONE       <= (state_d == ST_DONE);
            O_DLWR       <= (state_d == ST_WRITE);
        end
    end

    // ------------------------------------------------------------------
    // Datapath: address/data only change when a new strobe starts, so they
    // stay stable through the gap and any wait for the next word.
    // ------------------------------------------------------------------
    always_ff @(posedge I_CLK_48M or negedge I_RSTn) begin
        if (!I_RSTn) begin
            word_q     <= '0;
            byte_idx_q <= '0;
            byte_cnt_q <= '0;
            O_DLADDR   <= '0;
            O_DLDATA   <= '0;
            O_ERR      <= 1'b0;
        end else if (clear_all) begin
            word_q     <= '0;
            byte_idx_q <= '0;
            byte_cnt_q <= '0;
            O_DLADDR   <= '0;
            O_DLDATA   <= '0;
            O_ERR      <= 1'b0;
        end else begin
            if (accept) begin
                word_q     <= {I_WORD[23:0], 8'h00};
                O_DLDATA   <= I_WORD[31:24];
                byte_idx_q <= 2'd0;
                O_DLADDR   <= byte_cnt_q;
            end
            if (byte_done) begin
                byte_cnt_q <= byte_cnt_inc;
            end
            if (next_byte) begin
                word_q     <= {word_q[23:0], 8'h00};
                O_DLDATA   <= word_q[31:24];
                byte_idx_q <= byte_idx_q + 2'd1;
                O_DLADDR   <= byte_cnt_inc;
            end
            if (overflow || csum_err) begin
                O_ERR <= 1'b1;
            end
        end
    end

`ifdef MARIO_DL_CHECKSUM_EN
    // The sum is updated on the same edge that launches each strobe, so it
    // already includes the final byte by the time DONE is entered.
    logic                 csum_en;
    logic [DL_DATA_W-1:0] csum_byte;
    logic                 enter_done;

    assign csum_en    = accept | next_byte;
    assign csum_byte  = accept ? I_WORD[31:24] : word_q[31:24];
    assign enter_done = byte_done & (state_d == ST_DONE);
    assign csum_err   = enter_done & (O_CSUM != I_CSUM_EXP);

    mario_dl_csum u_csum (
        .I_CLK_48M (I_CLK_48M),
        .I_RSTn    (I_RSTn),
        .clr       (clear_all),
        .en        (csum_en),
        .add_byte  (csum_byte),
        .sum       (O_CSUM)
    );
`else
    logic csum_exp_unused;

    assign csum_err        = 1'b0;
    assign O_CSUM          = '0;
    assign csum_exp_unused = ^I_CSUM_EXP;
`endif

endmodule
